// File: rtl/piso8_serializer.sv
// -----------------------------------------------------------------------------
// piso8_serializer
//   Parallel-to-serial converter feeding the 8-bit serial shift register stage.
//   Bytes arrive over a valid/ready handshake and leave MSB-first, one bit per
//   clock, qualified by sout_valid. A one-entry holding register lets the next
//   byte wait while the current frame shifts, so frames run back-to-back with
//   no idle cycle between them.
//
//   Optional feature: define PISO8_PARITY_EN to append an even-parity bit
//   (XOR of the 8 data bits) after bit 0, making each frame 9 bits long.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   din[7:0]     parallel byte to serialize
//   din_valid    din is valid this cycle
//   din_ready    a byte can be accepted this cycle (= hold register empty)
//   sout         serial data, MSB first
//   sout_valid   sout carries a frame bit this cycle
//   frame_start  high on the cycle carrying a frame's first bit
//   busy         engine is shifting or the holding register is full
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | no frame in progress, outputs quiet
// S_SHIFT | emitting sreg MSB each cycle, cnt = index of bit being driven
// -----------------------------------------------------------------------------
module piso8_serializer (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic       sout,
    output logic       sout_valid,
    output logic       frame_start,
    output logic       busy
);

`ifdef PISO8_PARITY_EN
    localparam int N = 9;
`else
    localparam int N = 8;
`endif
    localparam logic [3:0] LAST_CNT = 4'(N - 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    logic [0:0]   state;
    logic [N-1:0] sreg;
    logic [3:0]   cnt;
    logic [7:0]   hold;
    logic         hold_full;

    logic accept;
    logic last_bit;

    // Shift-register image of a byte: data MSB-aligned, parity (if any) last.
    function automatic logic [N-1:0] frame_of(input logic [7:0] b);
`ifdef PISO8_PARITY_EN
        return {b, ^b};
`else
        return b;
`endif
    endfunction

    assign din_ready   = !hold_full;
    assign accept      = din_valid && din_ready;
    assign last_bit    = (state == S_SHIFT) && (cnt == LAST_CNT);

    assign sout_valid  = (state == S_SHIFT);
    assign sout        = sout_valid ? sreg[N-1] : 1'b0;
    assign frame_start = sout_valid && (cnt == 4'd0);
    assign busy        = (state == S_SHIFT) || hold_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            sreg      <= '0;
            cnt       <= 4'd0;
            hold      <= 8'd0;
            hold_full <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        sreg  <= frame_of(din);
                        cnt   <= 4'd0;
                        state <= S_SHIFT;
                    end
                end
                default: begin
                    if (last_bit) begin
                        // hold_full forces din_ready low, so a drain and a
                        // direct accept can never collide here.
                        if (hold_full) begin
                            sreg      <= frame_of(hold);
                            hold_full <= 1'b0;
                            cnt       <= 4'd0;
                        end else if (accept) begin
                            sreg <= frame_of(din);
                            cnt  <= 4'd0;
                        end else begin
                            sreg  <= '0;
                            cnt   <= 4'd0;
                            state <= S_IDLE;
                        end
                    end else begin
                        sreg <= sreg << 1;
                        cnt  <= cnt + 4'd1;
                        if (accept) begin
                            hold      <= din;
                            hold_full <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piso8_serializer.sv
module tb_piso8_serializer;

`ifdef PISO8_PARITY_EN
    localparam int N = 9;
`else
    localparam int N = 8;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready;
    logic       sout;
    logic       sout_valid;
    logic       frame_start;
    logic       busy;

    piso8_serializer dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .sout       (sout),
        .sout_valid (sout_valid),
        .frame_start(frame_start),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic b;
        logic first;
    } exp_bit_t;

    exp_bit_t exp_q[$];
    int       n_checks = 0;
    int       n_fail   = 0;
    logic     checking = 1'b0;

    function automatic void check(input string name, input logic act, input logic req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0b required=%0b at t=%0t", name, act, req, $time);
        end
    endfunction

    // Reference model: a frame is the byte's bits from 7 down to 0, followed by
    // the even-parity bit when parity is enabled.
    function automatic void push_frame(input logic [7:0] d);
        for (int i = 7; i >= 0; i--) exp_q.push_back('{b: d[i], first: (i == 7)});
`ifdef PISO8_PARITY_EN
        exp_q.push_back('{b: ^d, first: 1'b0});
`endif
    endfunction

    // Monitor: everything still queued must come out contiguously. The bits
    // queued also tell how full the block is: more than one frame outstanding
    // means a byte is waiting in hold.
    exp_bit_t e;
    int       sz;
    always @(negedge clk) begin
        if (checking) begin
            sz = exp_q.size();
            check("din_ready", din_ready, sz <= N);
            check("busy", busy, sz != 0);
            if (sz == 0) begin
                check("sout_valid_idle", sout_valid, 1'b0);
                check("sout_idle", sout, 1'b0);
                check("frame_start_idle", frame_start, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check("sout_valid_frame", sout_valid, 1'b1);
                check("sout_bit", sout, e.b);
                check("frame_start", frame_start, e.first);
            end
        end
    end

    task automatic cycle(input logic v, input logic [7:0] d, input logic r, output logic acc);
        @(negedge clk);
        #2;
        din       = d;
        din_valid = v;
        rst       = r;
        #1;
        acc = v && din_ready;
        @(posedge clk);
        if (r) exp_q.delete();
        else if (acc) push_frame(d);
    endtask

    task automatic send(input logic [7:0] d);
        logic acc;
        for (int k = 0; k < 40; k++) begin
            cycle(1'b1, d, 1'b0, acc);
            if (acc) return;
        end
        n_checks++;
        n_fail++;
        $display("FAIL send_timeout byte=%02h not accepted within 40 cycles", d);
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int k = 0; k < n; k++) cycle(1'b0, 8'($urandom), 1'b0, acc);
    endtask

    initial begin
        logic acc;
        rst       = 1'b1;
        din       = 8'd0;
        din_valid = 1'b0;
        repeat (2) @(posedge clk);
        checking = 1'b1;
        cycle(1'b0, 8'd0, 1'b1, acc);
        idle(2);

        // single byte from idle
        send(8'hA5);
        idle(12);

        // back-to-back with valid held: second goes to hold, third waits
        send(8'h3C);
        send(8'hC3);
        send(8'h5A);
        idle(30);

        // byte presented exactly on the last-bit cycle with hold empty
        send(8'h96);
        idle(N - 1);
        send(8'h69);
        idle(12);

        // reset while bit 3 of 8'hFF is on the line, then a clean frame
        send(8'hFF);
        idle(4);
        cycle(1'b0, 8'h00, 1'b1, acc);
        idle(2);
        send(8'h01);
        idle(12);

        // din_valid toggling while hold is full must not capture anything
        send(8'hF0);
        send(8'h0F);
        for (int k = 0; k < 6; k++) cycle(k[0], 8'($urandom), 1'b0, acc);
        idle(30);

        // parity-sensitive bytes
        send(8'h07);
        send(8'h03);
        idle(25);

        // random traffic with occasional reset
        for (int k = 0; k < 500; k++)
            cycle($urandom_range(0, 99) < 60, 8'($urandom), $urandom_range(0, 199) == 0, acc);

        for (int k = 0; k < 40 && exp_q.size() != 0; k++) idle(1);
        idle(3);
        check("drained", exp_q.size() == 0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
